// File: rtl/uart2axi_pkg.sv
// Shared types and constants for the UART2AXI bridge datapath blocks.
package uart2axi_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    ACK  = 2'd2,
    DONE = 2'd3
  } piso_state_t;

  localparam int BYTE_W = 8;

endpackage

// File: rtl/piso_tx.sv
// Transmit-path word serializer: takes one word from the stream side and feeds
// it MSB-first, one byte per handshake, to the UART transmitter.
//
// state | meaning
// IDLE  | ready for a word from the stream side
// SEND  | waiting for the UART TX to be free, then strobe the top byte
// ACK   | waiting for pi_tx_busy to rise, bounded by ACK_TIMEOUT
// DONE  | waiting for pi_tx_busy to fall; last byte closes the word
module piso_tx
  import uart2axi_pkg::*;
#(
  parameter int DATA_WIDTH  = BYTE_W,
  parameter int FIFO_DEPTH  = 4,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                           pi_clk,
  input  logic                           pi_rst,
  input  logic [DATA_WIDTH*FIFO_DEPTH-1:0] pi_data,
  input  logic                           pi_data_valid,
  input  logic                           pi_tlast,
  output logic                           po_ready,
  output logic [DATA_WIDTH-1:0]          po_data,
  output logic                           po_write_en,
  input  logic                           pi_tx_busy,
  output logic                           po_tlast_over,
  output logic                           po_ack_timeout
);

  localparam int WORD_W = DATA_WIDTH * FIFO_DEPTH;
  localparam int CNT_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TO_W   = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FIFO_DEPTH - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

  piso_state_t       state, state_nxt;
  logic [WORD_W-1:0] shift_reg;
  logic              tlast_q;
  logic [CNT_W-1:0]  byte_cnt;
  logic [TO_W-1:0]   to_cnt;

  logic load, strobe, to_clr, to_inc, to_fire, cnt_inc, tlast_fire;

  // Gated with reset so the source never sees ready while the block is held.
  assign po_ready = (state == IDLE) && !pi_rst;

  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    strobe     = 1'b0;
    to_clr     = 1'b0;
    to_inc     = 1'b0;
    to_fire    = 1'b0;
    cnt_inc    = 1'b0;
    tlast_fire = 1'b0;
    case (state)
      IDLE: begin
        if (pi_data_valid) begin
          load      = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        if (!pi_tx_busy) begin
          strobe    = 1'b1;
          to_clr    = 1'b1;
          state_nxt = ACK;
        end
      end
      ACK: begin
        if (pi_tx_busy) begin
          state_nxt = DONE;
        end else if (to_cnt == TO_LAST) begin
          // No acknowledge from the TX: treat the byte as sent and move on.
          to_fire   = 1'b1;
          state_nxt = DONE;
        end else begin
          to_inc = 1'b1;
        end
      end
      DONE: begin
        if (!pi_tx_busy) begin
          if (byte_cnt == CNT_LAST) begin
            tlast_fire = tlast_q;
            state_nxt  = IDLE;
          end else begin
            cnt_inc   = 1'b1;
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pi_clk) begin
    if (pi_rst) begin
      state          <= IDLE;
      shift_reg      <= '0;
      tlast_q        <= 1'b0;
      byte_cnt       <= '0;
      to_cnt         <= '0;
      po_data        <= '0;
      po_write_en    <= 1'b0;
      po_tlast_over  <= 1'b0;
      po_ack_timeout <= 1'b0;
    end else begin
      state          <= state_nxt;
      po_write_en    <= strobe;
      po_tlast_over  <= tlast_fire;
      po_ack_timeout <= to_fire;
      if (load) begin
        shift_reg <= pi_data;
        tlast_q   <= pi_tlast;
        byte_cnt  <= '0;
      end else if (strobe) begin
        po_data   <= shift_reg[WORD_W-1 -: DATA_WIDTH];
        shift_reg <= shift_reg << DATA_WIDTH;
      end
      if (cnt_inc) byte_cnt <= byte_cnt + CNT_W'(1);
      if (to_clr) to_cnt <= '0;
      else if (to_inc) to_cnt <= to_cnt + TO_W'(1);
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx with a simple UART TX busy model.
module tb_piso_tx;
  import uart2axi_pkg::*;

  logic        pi_clk = 1'b0;
  logic        pi_rst = 1'b1;
  logic [31:0] pi_data = '0;
  logic        pi_data_valid = 1'b0;
  logic        pi_tlast = 1'b0;
  logic        po_ready;
  logic [7:0]  po_data;
  logic        po_write_en;
  logic        pi_tx_busy;
  logic        po_tlast_over;
  logic        po_ack_timeout;

  piso_tx #(.DATA_WIDTH(8), .FIFO_DEPTH(4), .ACK_TIMEOUT(16)) dut (
    .pi_clk        (pi_clk),
    .pi_rst        (pi_rst),
    .pi_data       (pi_data),
    .pi_data_valid (pi_data_valid),
    .pi_tlast      (pi_tlast),
    .po_ready      (po_ready),
    .po_data       (po_data),
    .po_write_en   (po_write_en),
    .pi_tx_busy    (pi_tx_busy),
    .po_tlast_over (po_tlast_over),
    .po_ack_timeout(po_ack_timeout)
  );

  always #5 pi_clk = ~pi_clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;

  // UART TX model: busy rises the edge after a strobe and stays high busy_len cycles.
  logic model_busy = 1'b0;
  logic force_busy = 1'b0;
  bit   model_on = 1'b1;
  int   busy_len = 10;
  int   busy_cnt = 0;
  assign pi_tx_busy = model_busy | force_busy;

  always @(posedge pi_clk) cyc <= cyc + 1;

  always @(posedge pi_clk) begin
    if (model_on && po_write_en) begin
      model_busy <= 1'b1;
      busy_cnt   <= busy_len;
    end else if (busy_cnt > 1) begin
      busy_cnt <= busy_cnt - 1;
    end else if (busy_cnt == 1) begin
      model_busy <= 1'b0;
      busy_cnt   <= 0;
    end
  end

  logic [7:0] bytes_q[$];
  int stb_q[$];
  int tl_q[$];
  int to_q[$];

  always @(negedge pi_clk) begin
    if (po_write_en) begin
      bytes_q.push_back(po_data);
      stb_q.push_back(cyc);
    end
    if (po_tlast_over) tl_q.push_back(cyc);
    if (po_ack_timeout) to_q.push_back(cyc);
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(negedge pi_clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    bytes_q.delete();
    stb_q.delete();
    tl_q.delete();
    to_q.delete();
  endtask

  task automatic wait_ready(input string tag, output int rc);
    for (int i = 0; i < 600 && !po_ready; i++) tick();
    chk({tag, "_ready"}, {31'd0, po_ready}, 32'd1);
    rc = cyc;
  endtask

  task automatic check_bytes(input string tag, input logic [31:0] word, input int base);
    logic [31:0] w;
    w = word;
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_byte%0d", tag, k), {24'd0, bytes_q[base + k]}, {24'd0, w[31 - 8*k -: 8]});
  endtask

  initial begin
    int hs, rc, c;

    // Reset
    tick(2);
    chk("rst_ready", {31'd0, po_ready}, 32'd0);
    chk("rst_wen", {31'd0, po_write_en}, 32'd0);
    chk("rst_data", {24'd0, po_data}, 32'd0);
    chk("rst_tlo", {30'd0, po_tlast_over, po_ack_timeout}, 32'd0);
    pi_rst = 1'b0;
    tick();
    chk("rel_ready", {31'd0, po_ready}, 32'd1);

    // 1: single word, no tlast
    clr();
    pi_data = 32'hA1B2C3D4; pi_tlast = 1'b0; pi_data_valid = 1'b1;
    tick();
    hs = cyc;
    pi_data_valid = 1'b0;
    chk("t1_busy_ready", {31'd0, po_ready}, 32'd0);
    tick();
    chk("t1_wen", {31'd0, po_write_en}, 32'd1);
    chk("t1_data0", {24'd0, po_data}, 32'hA1);
    chk("t1_lat", stb_q[0], hs + 1);
    wait_ready("t1", rc);
    chk("t1_tlo_at_ready", {31'd0, po_tlast_over}, 32'd0);
    chk("t1_count", bytes_q.size(), 4);
    check_bytes("t1", 32'hA1B2C3D4, 0);
    for (int i = 0; i < 3; i++) chk($sformatf("t1_gap%0d", i), stb_q[i+1] - stb_q[i], 13);
    chk("t1_ready_cyc", rc, stb_q[3] + 12);
    chk("t1_hold", {24'd0, po_data}, 32'hD4);
    chk("t1_no_tlo", tl_q.size(), 0);
    chk("t1_no_to", to_q.size(), 0);

    // 2: tlast word
    clr();
    pi_data = 32'h01020304; pi_tlast = 1'b1; pi_data_valid = 1'b1;
    tick();
    pi_data_valid = 1'b0; pi_tlast = 1'b0;
    wait_ready("t2", rc);
    chk("t2_tlo_at_ready", {31'd0, po_tlast_over}, 32'd1);
    check_bytes("t2", 32'h01020304, 0);
    chk("t2_tlo_cyc", tl_q[0], stb_q[3] + 12);
    tick(3);
    chk("t2_tlo_once", tl_q.size(), 1);
    chk("t2_tlo_low", {31'd0, po_tlast_over}, 32'd0);

    // 3: back-to-back words, valid held
    clr();
    pi_data = 32'h11223344; pi_data_valid = 1'b1;
    tick();
    pi_data = 32'h55667788;
    tick();
    wait_ready("t3a", rc);
    tick();
    pi_data_valid = 1'b0;
    wait_ready("t3b", rc);
    chk("t3_count", bytes_q.size(), 8);
    check_bytes("t3w0", 32'h11223344, 0);
    check_bytes("t3w1", 32'h55667788, 4);
    for (int i = 0; i < 7; i++)
      chk($sformatf("t3_gap%0d", i), stb_q[i+1] - stb_q[i], (i == 3) ? 14 : 13);
    chk("t3_no_tlo", tl_q.size(), 0);

    // 4: TX busy at accept for 20 cycles
    clr();
    tick();
    force_busy = 1'b1;
    pi_data = 32'hDEADBEEF; pi_data_valid = 1'b1;
    tick();
    pi_data_valid = 1'b0;
    tick(19);
    chk("t4_stall", bytes_q.size(), 0);
    chk("t4_stall_wen", {31'd0, po_write_en}, 32'd0);
    c = cyc;
    force_busy = 1'b0;
    wait_ready("t4", rc);
    chk("t4_first_cyc", stb_q[0], c + 1);
    check_bytes("t4", 32'hDEADBEEF, 0);

    // 5: TX never acknowledges
    clr();
    model_on = 1'b0;
    tick();
    pi_data = 32'h5AC396E1; pi_data_valid = 1'b1;
    tick();
    pi_data_valid = 1'b0;
    wait_ready("t5", rc);
    chk("t5_to_count", to_q.size(), 4);
    check_bytes("t5", 32'h5AC396E1, 0);
    for (int i = 0; i < 4; i++) chk($sformatf("t5_to%0d", i), to_q[i], stb_q[i] + 16);
    for (int i = 0; i < 3; i++) chk($sformatf("t5_gap%0d", i), stb_q[i+1] - stb_q[i], 18);
    chk("t5_ready_cyc", rc, stb_q[3] + 17);
    chk("t5_no_tlo", tl_q.size(), 0);

    // 6: reset after the second byte
    clr();
    model_on = 1'b1;
    pi_data = 32'h0A0B0C0D; pi_tlast = 1'b1; pi_data_valid = 1'b1;
    tick();
    pi_data_valid = 1'b0; pi_tlast = 1'b0;
    for (int i = 0; i < 200 && bytes_q.size() < 2; i++) tick();
    chk("t6_two_bytes", bytes_q.size(), 2);
    pi_rst = 1'b1;
    tick();
    chk("t6_rst_ready", {31'd0, po_ready}, 32'd0);
    chk("t6_rst_wen", {31'd0, po_write_en}, 32'd0);
    chk("t6_rst_data", {24'd0, po_data}, 32'd0);
    pi_rst = 1'b0;
    tick();
    chk("t6_rel_ready", {31'd0, po_ready}, 32'd1);
    tick(40);
    chk("t6_no_more", bytes_q.size(), 2);
    chk("t6_no_tlo", tl_q.size(), 0);
    chk("t6_idle", {31'd0, po_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
